// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game-state controller: button edge detection, board, turns, cursor and result.
// Optional per-turn time limit enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_board_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       move_pulse,
  input  logic       assign_pulse,
  output logic [1:0] cell1,
  output logic [1:0] cell2,
  output logic [1:0] cell3,
  output logic [1:0] cell4,
  output logic [1:0] cell5,
  output logic [1:0] cell6,
  output logic [1:0] cell7,
  output logic [1:0] cell8,
  output logic [1:0] cell9,
  output logic [3:0] cursor_pos,
  output logic       turn_p1,
  output logic       turn_p2,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       invalid_move,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, P1_TURN, P2_TURN, CHECK, GAME_OVER} state_t;

  state_t     state_q, state_d;
  logic [1:0] cells_q [9];
  logic [1:0] cells_d [9];
  logic [3:0] cursor_q, cursor_d;
  logic [1:0] winner_q, winner_d;
  logic       over_q, over_d;
  logic       invalid_q, invalid_d;
  logic       mover_p2_q, mover_p2_d;
  logic [2:0] btn_q, btn_prev_q;
  logic       start_ev, move_ev, assign_ev;
  logic [3:0] cur_idx;
  logic [1:0] mark;
  logic [1:0] line_win;
  logic       board_full;

  // Bit order of the button history: {start, move, assign}
  assign start_ev  = btn_q[2] & ~btn_prev_q[2];
  assign move_ev   = btn_q[1] & ~btn_prev_q[1];
  assign assign_ev = btn_q[0] & ~btn_prev_q[0];
  assign cur_idx   = cursor_q - 4'd1;
  assign mark      = (state_q == P2_TURN) ? 2'b10 : 2'b01;

  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  always_comb begin
    logic [1:0] lw [8];
    lw[0] = line3(cells_q[0], cells_q[1], cells_q[2]);
    lw[1] = line3(cells_q[3], cells_q[4], cells_q[5]);
    lw[2] = line3(cells_q[6], cells_q[7], cells_q[8]);
    lw[3] = line3(cells_q[0], cells_q[3], cells_q[6]);
    lw[4] = line3(cells_q[1], cells_q[4], cells_q[7]);
    lw[5] = line3(cells_q[2], cells_q[5], cells_q[8]);
    lw[6] = line3(cells_q[0], cells_q[4], cells_q[8]);
    lw[7] = line3(cells_q[2], cells_q[4], cells_q[6]);
    line_win   = 2'b00;
    board_full = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (line_win == 2'b00) line_win = lw[i];
    end
    for (int unsigned i = 0; i < 9; i++) begin
      if (cells_q[i] == 2'b00) board_full = 1'b0;
    end
  end

`ifdef TTT_TURN_TIMEOUT_EN
  localparam logic [27:0] LAST_CNT = 28'(TIMEOUT_CYCLES - 1);
  logic [27:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    cursor_d   = cursor_q;
    winner_d   = winner_q;
    over_d     = over_q;
    invalid_d  = 1'b0;
    mover_p2_d = mover_p2_q;
`ifdef TTT_TURN_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_ev) begin
          cells_d  = '{default: '0};
          cursor_d = 4'd1;
          winner_d = 2'b00;
          over_d   = 1'b0;
          state_d  = P1_TURN;
        end
      end
      P1_TURN, P2_TURN: begin
        if (start_ev) begin
          cells_d  = '{default: '0};
          cursor_d = 4'd1;
          winner_d = 2'b00;
          over_d   = 1'b0;
          state_d  = P1_TURN;
        end else if (assign_ev) begin
          if (cells_q[cur_idx] == 2'b00) begin
            cells_d[cur_idx] = mark;
            mover_p2_d       = (state_q == P2_TURN);
            state_d          = CHECK;
          end else begin
            invalid_d = 1'b1;
          end
        end else if (move_ev) begin
          cursor_d = (cursor_q == 4'd9) ? 4'd1 : cursor_q + 4'd1;
`ifdef TTT_TURN_TIMEOUT_EN
        end else if (cnt_q == LAST_CNT) begin
          state_d   = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
          timeout_d = 1'b1;
`endif
        end
      end
      CHECK: begin
        if (line_win != 2'b00) begin
          winner_d = line_win;
          over_d   = 1'b1;
          state_d  = GAME_OVER;
        end else if (board_full) begin
          winner_d = 2'b11;
          over_d   = 1'b1;
          state_d  = GAME_OVER;
        end else begin
          state_d = mover_p2_q ? P1_TURN : P2_TURN;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TTT_TURN_TIMEOUT_EN
    // Any event or state change restarts the turn timer; it only runs while a turn is undisturbed.
    if ((state_q == P1_TURN || state_q == P2_TURN) && state_d == state_q &&
        !(start_ev || move_ev || assign_ev))
      cnt_d = cnt_q + 28'd1;
    else
      cnt_d = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cells_q    <= '{default: '0};
      cursor_q   <= 4'd1;
      winner_q   <= 2'b00;
      over_q     <= 1'b0;
      invalid_q  <= 1'b0;
      mover_p2_q <= 1'b0;
      btn_q      <= '0;
      btn_prev_q <= '0;
`ifdef TTT_TURN_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cells_q    <= cells_d;
      cursor_q   <= cursor_d;
      winner_q   <= winner_d;
      over_q     <= over_d;
      invalid_q  <= invalid_d;
      mover_p2_q <= mover_p2_d;
      btn_q      <= {start_pulse, move_pulse, assign_pulse};
      btn_prev_q <= btn_q;
`ifdef TTT_TURN_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign cell1        = cells_q[0];
  assign cell2        = cells_q[1];
  assign cell3        = cells_q[2];
  assign cell4        = cells_q[3];
  assign cell5        = cells_q[4];
  assign cell6        = cells_q[5];
  assign cell7        = cells_q[6];
  assign cell8        = cells_q[7];
  assign cell9        = cells_q[8];
  assign cursor_pos   = cursor_q;
  assign turn_p1      = (state_q == P1_TURN);
  assign turn_p2      = (state_q == P2_TURN);
  assign winner       = winner_q;
  assign game_over    = over_q;
  assign invalid_move = invalid_q;
`ifdef TTT_TURN_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  // Time limit not built; the parameter is referenced only to keep it part of the interface.
  assign timeout      = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Self-checking bench for ttt_board_ctrl: directed game scenarios plus random button play
// checked against a board-level reference model. Honours TTT_TURN_TIMEOUT_EN.
module tb_ttt_board_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_pulse, move_pulse, assign_pulse;
  logic [1:0] cell1, cell2, cell3, cell4, cell5, cell6, cell7, cell8, cell9;
  logic [3:0] cursor_pos;
  logic       turn_p1, turn_p2;
  logic [1:0] winner;
  logic       game_over, invalid_move, timeout;

  ttt_board_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .start_pulse(start_pulse), .move_pulse(move_pulse), .assign_pulse(assign_pulse),
    .cell1(cell1), .cell2(cell2), .cell3(cell3), .cell4(cell4), .cell5(cell5),
    .cell6(cell6), .cell7(cell7), .cell8(cell8), .cell9(cell9),
    .cursor_pos(cursor_pos), .turn_p1(turn_p1), .turn_p2(turn_p2),
    .winner(winner), .game_over(game_over),
    .invalid_move(invalid_move), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int inv_seen = 0;
  int to_seen  = 0;

  always @(negedge clock) begin
    if (invalid_move === 1'b1) inv_seen++;
    if (timeout === 1'b1) to_seen++;
  end

  // Reference model: board contents 0/1/2, cursor 1..9, whose turn (0 = nobody may move)
  int m_board [9];
  int m_cur, m_turn, m_win, m_over, m_inv, m_to;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic model_reset();
    foreach (m_board[i]) m_board[i] = 0;
    m_cur = 1; m_turn = 0; m_win = 0; m_over = 0;
  endtask

  task automatic model_start();
    foreach (m_board[i]) m_board[i] = 0;
    m_cur = 1; m_turn = 1; m_win = 0; m_over = 0;
  endtask

  task automatic model_assign();
    int w;
    int filled;
    if (m_turn == 0) return;
    if (m_board[m_cur-1] != 0) begin
      m_inv++;
      return;
    end
    m_board[m_cur-1] = m_turn;
    w = 0;
    for (int l = 0; l < 8; l++)
      if (m_board[lines[l][0]] != 0 && m_board[lines[l][0]] == m_board[lines[l][1]] &&
          m_board[lines[l][1]] == m_board[lines[l][2]]) w = m_board[lines[l][0]];
    filled = 0;
    foreach (m_board[i]) if (m_board[i] != 0) filled++;
    if (w != 0)           begin m_win = w; m_over = 1; m_turn = 0; end
    else if (filled == 9) begin m_win = 3; m_over = 1; m_turn = 0; end
    else                  m_turn = 3 - m_turn;
  endtask

  task automatic model_move();
    if (m_turn != 0) m_cur = (m_cur % 9) + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [17:0] exp_cells;
    for (int i = 0; i < 9; i++) exp_cells[2*i +: 2] = 2'(m_board[i]);
    chk({tag, ".cells"}, 32'({cell9, cell8, cell7, cell6, cell5, cell4, cell3, cell2, cell1}),
        32'(exp_cells));
    chk({tag, ".cursor"},  32'(cursor_pos),   32'(m_cur));
    chk({tag, ".turn_p1"}, 32'(turn_p1),      32'(m_turn == 1));
    chk({tag, ".turn_p2"}, 32'(turn_p2),      32'(m_turn == 2));
    chk({tag, ".winner"},  32'(winner),       32'(m_win));
    chk({tag, ".over"},    32'(game_over),    32'(m_over));
    chk({tag, ".invalid"}, 32'(inv_seen),     32'(m_inv));
    chk({tag, ".timeout"}, 32'(to_seen),      32'(m_to));
  endtask

  // One-cycle button press, then enough idle cycles for edge detect, mark and CHECK to settle
  task automatic press(input bit s, input bit m, input bit a);
    @(negedge clock);
    start_pulse = s; move_pulse = m; assign_pulse = a;
    @(negedge clock);
    start_pulse = 0; move_pulse = 0; assign_pulse = 0;
    repeat (5) @(negedge clock);
  endtask

  task automatic do_start();  press(1, 0, 0); model_start();  endtask
  task automatic do_move();   press(0, 1, 0); model_move();   endtask
  task automatic do_assign(); press(0, 0, 1); model_assign(); endtask

  task automatic goto_cell(input int t);
    while (m_cur != t) do_move();
  endtask

  initial begin
    int fill [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int r;
    reset = 1; start_pulse = 0; move_pulse = 0; assign_pulse = 0;
    m_inv = 0; m_to = 0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 0;
    check_all("reset");

    // Move and assign are ignored before the first start
    do_move(); do_assign();
    check_all("idle_ignore");
    do_start();
    check_all("start");

    // P1 wins on the 1-5-9 diagonal
    do_assign();
    goto_cell(2); do_assign();
    goto_cell(5); do_assign();
    goto_cell(6); do_assign();
    goto_cell(9); do_assign();
    check_all("diag_win");
    chk("diag_win.const_winner", 32'(winner), 32'd1);
    chk("diag_win.const_cell5", 32'(cell5), 32'd1);
    do_move(); do_assign();
    check_all("frozen");

    // Assigning on an occupied cell
    do_start(); do_assign(); do_assign();
    check_all("invalid");
    chk("invalid.const_turn_p2", 32'(turn_p2), 32'd1);

    // Cursor walk with wrap from 9 to 1
    do_start();
    for (int i = 0; i < 9; i++) begin
      do_move();
      check_all("cursor_walk");
    end
    chk("cursor_wrap.const", 32'(cursor_pos), 32'd1);
    do_move(); do_move();
    press(0, 1, 1); model_assign();
    check_all("assign_beats_move");
    chk("assign_beats_move.const_cur", 32'(cursor_pos), 32'd3);

    // Draw game
    do_start();
    foreach (fill[i]) begin
      goto_cell(fill[i]);
      do_assign();
    end
    check_all("draw");
    chk("draw.const_winner", 32'(winner), 32'd3);
    do_assign();
    check_all("draw_frozen");
    do_start();
    check_all("restart_after_draw");

    // Idle turn: forfeits only when the time limit is built
    do_start();
    repeat (24) @(negedge clock);
`ifdef TTT_TURN_TIMEOUT_EN
    m_to++; m_turn = 2;
`endif
    check_all("turn_idle");

    // Reset mid-game
    do_move(); do_assign();
    @(negedge clock); reset = 1;
    @(negedge clock); @(negedge clock); reset = 0;
    model_reset();
    check_all("mid_reset");

    // Random play
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 99));
      if (m_turn == 0 && r < 40) do_start();
      else if (r < 4)  do_start();
      else if (r < 45) do_move();
      else if (r < 88) do_assign();
      else begin press(0, 1, 1); model_assign(); end
      check_all("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
